// File: rtl/clip_pkg.sv
// Shared types and constants for the line-segment clip controller:
// vertex layout, FSM state encoding and the clip-plane coefficient table.
package clip_pkg;

  localparam int COMP_W      = 20;
  localparam int NUM_PLANES  = 6;
  localparam int PLANE_IDX_W = 3;

  typedef logic signed [COMP_W-1:0] comp_t;

  typedef struct packed {
    comp_t x;
    comp_t y;
    comp_t z;
    comp_t w;
  } vec4_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_TEST  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_OUT   = 3'd4
  } state_t;

  // Coefficients are only ever -1, 0 or +1, so two signed bits each.
  typedef struct packed {
    logic signed [1:0] a;
    logic signed [1:0] b;
    logic signed [1:0] c;
    logic signed [1:0] d;
  } plane_coef_t;

  localparam plane_coef_t PLANE_W_ONLY = '{a: 2'sd0, b: 2'sd0, c: 2'sd0, d: 2'sd1};

  localparam plane_coef_t PLANE_TAB [NUM_PLANES] = '{
    '{a:  2'sd1, b:  2'sd0, c:  2'sd0, d: 2'sd1},
    '{a: -2'sd1, b:  2'sd0, c:  2'sd0, d: 2'sd1},
    '{a:  2'sd0, b:  2'sd1, c:  2'sd0, d: 2'sd1},
    '{a:  2'sd0, b: -2'sd1, c:  2'sd0, d: 2'sd1},
    '{a:  2'sd0, b:  2'sd0, c:  2'sd1, d: 2'sd1},
    '{a:  2'sd0, b:  2'sd0, c: -2'sd1, d: 2'sd1}
  };

  function automatic plane_coef_t plane_coef(input logic [PLANE_IDX_W-1:0] idx);
    plane_coef_t c;
    c = PLANE_W_ONLY;
    if (int'(idx) < NUM_PLANES) c = PLANE_TAB[idx];
    return c;
  endfunction

endpackage

// File: rtl/clip_plane_dist.sv
// Signed distance of both segment endpoints to one clip plane, plus
// inside flags (distance >= 0). Purely combinational.
module clip_plane_dist
  import clip_pkg::*;
#(
  parameter int WIDTH = COMP_W
) (
  input  logic [PLANE_IDX_W-1:0] plane_idx_i,
  input  logic [4*WIDTH-1:0]     v1_i,
  input  logic [4*WIDTH-1:0]     v2_i,
  output logic signed [WIDTH:0]  d1_o,
  output logic signed [WIDTH:0]  d2_o,
  output logic                   in1_o,
  output logic                   in2_o
);

  plane_coef_t coef;

  // One extra bit of headroom: at most two non-zero terms are summed.
  function automatic logic signed [WIDTH:0] plane_dist(
    input logic [4*WIDTH-1:0] v,
    input plane_coef_t        c
  );
    logic [7:0]            c_bits;
    logic [WIDTH-1:0]      comp;
    logic signed [WIDTH:0] comp_x;
    logic signed [WIDTH:0] acc;
    c_bits = c;
    acc    = '0;
    for (int i = 0; i < 4; i++) begin
      comp   = v[(3-i)*WIDTH +: WIDTH];
      comp_x = {comp[WIDTH-1], comp};
      case (c_bits[(3-i)*2 +: 2])
        2'b01:   acc = acc + comp_x;
        2'b11:   acc = acc - comp_x;
        default: acc = acc;
      endcase
    end
    return acc;
  endfunction

  always_comb begin
    coef  = plane_coef(plane_idx_i);
    d1_o  = plane_dist(v1_i, coef);
    d2_o  = plane_dist(v2_i, coef);
    in1_o = (d1_o >= 0);
    in2_o = (d2_o >= 0);
  end

endmodule

// File: rtl/clip_line_ctrl.sv
// Segment clip controller: tests one plane per cycle and hands crossing edges to an
// external intersection unit. CLIP_ZPLANES_EN enables the two z planes (default: x/y only).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | ready for a new segment
// ST_TEST  | classify both endpoints against plane plane_q
// ST_ISSUE | one-cycle start pulse to the intersection unit
// ST_WAIT  | operands held until the intersection point returns
// ST_OUT   | result presented until accepted
module clip_line_ctrl
  import clip_pkg::*;
#(
  parameter int WIDTH = COMP_W
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [4*WIDTH-1:0] in_v1_i,
  input  logic [4*WIDTH-1:0] in_v2_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [4*WIDTH-1:0] out_v1_o,
  output logic [4*WIDTH-1:0] out_v2_o,
  output logic               out_reject_o,
  output logic               isect_start_o,
  output logic [4*WIDTH-1:0] isect_v1_o,
  output logic [4*WIDTH-1:0] isect_v2_o,
  output logic [4*WIDTH-1:0] isect_plane_o,
  input  logic               isect_done_i,
  input  logic [4*WIDTH-1:0] isect_p_i
);

`ifdef CLIP_ZPLANES_EN
  localparam int ACTIVE_PLANES = NUM_PLANES;
`else
  localparam int ACTIVE_PLANES = 4;
`endif
  localparam logic [PLANE_IDX_W-1:0] LAST_PLANE = PLANE_IDX_W'(ACTIVE_PLANES - 1);

  state_t                   state_q, state_d;
  logic [4*WIDTH-1:0]       v1_q, v1_d;
  logic [4*WIDTH-1:0]       v2_q, v2_d;
  logic [PLANE_IDX_W-1:0]   plane_q, plane_d;
  logic                     reject_q, reject_d;

  logic signed [WIDTH:0]    d1, d2;
  logic                     in1, in2;
  logic                     last_plane;
  plane_coef_t              cur_coef;
  logic [4*WIDTH-1:0]       cur_plane;

  clip_plane_dist #(
    .WIDTH (WIDTH)
  ) u_dist (
    .plane_idx_i (plane_q),
    .v1_i        (v1_q),
    .v2_i        (v2_q),
    .d1_o        (d1),
    .d2_o        (d2),
    .in1_o       (in1),
    .in2_o       (in2)
  );

  // Unit coefficient expressed in 12.8 fixed point.
  function automatic logic [WIDTH-1:0] coef_fx(input logic signed [1:0] k);
    return {{(WIDTH-10){k[1]}}, k, 8'h00};
  endfunction

  always_comb begin
    cur_coef   = plane_coef(plane_q);
    cur_plane  = {coef_fx(cur_coef.a), coef_fx(cur_coef.b),
                  coef_fx(cur_coef.c), coef_fx(cur_coef.d)};
    last_plane = (plane_q == LAST_PLANE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      v1_q     <= '0;
      v2_q     <= '0;
      plane_q  <= '0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      plane_q  <= plane_d;
      reject_q <= reject_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    v1_d          = v1_q;
    v2_d          = v2_q;
    plane_d       = plane_q;
    reject_d      = reject_q;
    in_ready_o    = 1'b0;
    out_valid_o   = 1'b0;
    isect_start_o = 1'b0;
    isect_v1_o    = '0;
    isect_v2_o    = '0;
    isect_plane_o = '0;

    case (state_q)
      ST_IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          v1_d     = in_v1_i;
          v2_d     = in_v2_i;
          plane_d  = '0;
          reject_d = 1'b0;
          state_d  = ST_TEST;
        end
      end

      ST_TEST: begin
        if (in1 && in2) begin
          if (last_plane) begin
            state_d = ST_OUT;
          end else begin
            plane_d = plane_q + 1'b1;
            state_d = ST_TEST;
          end
        end else if (!in1 && !in2) begin
          reject_d = 1'b1;
          state_d  = ST_OUT;
        end else begin
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        isect_start_o = 1'b1;
        isect_v1_o    = v1_q;
        isect_v2_o    = v2_q;
        isect_plane_o = cur_plane;
        state_d       = ST_WAIT;
      end

      ST_WAIT: begin
        isect_v1_o    = v1_q;
        isect_v2_o    = v2_q;
        isect_plane_o = cur_plane;
        if (isect_done_i) begin
          // Vertices are unchanged since TEST, so the distances still mark the outside end.
          if (d1 < 0) begin
            v1_d = isect_p_i;
          end else if (d2 < 0) begin
            v2_d = isect_p_i;
          end
          if (last_plane) begin
            state_d = ST_OUT;
          end else begin
            plane_d = plane_q + 1'b1;
            state_d = ST_TEST;
          end
        end
      end

      ST_OUT: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign out_v1_o     = v1_q;
  assign out_v2_o     = v2_q;
  assign out_reject_o = reject_q;

endmodule

// File: tb/tb_clip_line_ctrl.sv
// Directed bench for clip_line_ctrl; expected latencies follow CLIP_ZPLANES_EN
// (6 planes when defined, 4 otherwise) and must be built with the same define as the RTL.
module tb_clip_line_ctrl;
  import clip_pkg::*;

`ifdef CLIP_ZPLANES_EN
  localparam int NPL = 6;
`else
  localparam int NPL = 4;
`endif
  localparam int MAX_CYC = 100;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [79:0] in_v1_i = '0;
  logic [79:0] in_v2_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [79:0] out_v1_o, out_v2_o;
  logic        out_reject_o;
  logic        isect_start_o;
  logic [79:0] isect_v1_o, isect_v2_o, isect_plane_o;
  logic        isect_done_i = 1'b0;
  logic [79:0] isect_p_i = '0;

  clip_line_ctrl #(.WIDTH(20)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .in_v1_i       (in_v1_i),
    .in_v2_i       (in_v2_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_v1_o      (out_v1_o),
    .out_v2_o      (out_v2_o),
    .out_reject_o  (out_reject_o),
    .isect_start_o (isect_start_o),
    .isect_v1_o    (isect_v1_o),
    .isect_v2_o    (isect_v2_o),
    .isect_plane_o (isect_plane_o),
    .isect_done_i  (isect_done_i),
    .isect_p_i     (isect_p_i)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_mis = 0;

  int    lat, starts;
  vec4_t plane_s, iv1_s, iv2_s;
  bit    op_held, stable, idle_after;
  logic [79:0] o_v1, o_v2;
  logic        o_rej;

  task automatic check_val(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic vec4_t mk(input logic [19:0] x, input logic [19:0] y,
                               input logic [19:0] z, input logic [19:0] w);
    vec4_t v;
    v.x = x; v.y = y; v.z = z; v.w = w;
    return v;
  endfunction

  // Drives one segment, plays the intersection unit (done 'dly' cycles after start),
  // optionally pokes a stray done in the first TEST cycle, then holds OUT for 'hold' cycles.
  // lat counts edges from the handshake edge (= 1) until out_valid_o is seen.
  task automatic run_seg(input vec4_t v1, input vec4_t v2, input vec4_t p,
                         input int dly, input bit stray, input int hold);
    bit pend;
    int wcnt;
    pend = 0; wcnt = 0;
    starts = 0; plane_s = '0; iv1_s = '0; iv2_s = '0;
    op_held = 1; stable = 1;
    @(negedge clk_i);
    in_valid_i = 1'b1; in_v1_i = v1; in_v2_i = v2;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    lat = 1;
    while (!out_valid_o && lat < MAX_CYC) begin
      isect_done_i = 1'b0;
      isect_p_i    = '0;
      if (stray && lat == 1) begin
        isect_done_i = 1'b1;
        isect_p_i    = {4{20'h0ABCD}};
      end
      if (pend) begin
        if (isect_plane_o !== plane_s || isect_v1_o !== iv1_s || isect_v2_o !== iv2_s) op_held = 0;
        wcnt++;
        if (wcnt == dly) begin
          isect_done_i = 1'b1;
          isect_p_i    = p;
          pend         = 0;
        end
      end
      if (isect_start_o) begin
        starts++;
        plane_s = isect_plane_o;
        iv1_s   = isect_v1_o;
        iv2_s   = isect_v2_o;
        pend    = 1;
        wcnt    = 0;
      end
      @(posedge clk_i); #1;
      lat++;
    end
    isect_done_i = 1'b0;
    isect_p_i    = '0;
    o_v1 = out_v1_o; o_v2 = out_v2_o; o_rej = out_reject_o;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk_i); #1;
      if (!out_valid_o || in_ready_o || out_v1_o !== o_v1 || out_v2_o !== o_v2 ||
          out_reject_o !== o_rej) stable = 0;
    end
    out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    out_ready_i = 1'b0;
    idle_after = in_ready_o && !out_valid_o;
  endtask

  vec4_t va, vb, vp;
  int    n;

  initial begin
    // Reset values
    repeat (2) @(posedge clk_i);
    #1;
    check_val("rst_in_ready", in_ready_o, 1'b1);
    check_val("rst_out_valid", out_valid_o, 1'b0);
    check_val("rst_isect_start", isect_start_o, 1'b0);
    check_val("rst_reject", out_reject_o, 1'b0);
    check_val("rst_out_v1", out_v1_o, '0);
    check_val("rst_isect_plane", isect_plane_o, '0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Fully inside, with a stray done during TEST that must be ignored
    va = mk(20'h0, 20'h0, 20'h0, 20'h100);
    vb = mk(20'h80, 20'h0, 20'h0, 20'h100);
    run_seg(va, vb, '0, 1, 1'b1, 0);
    check_val("inside_lat", lat, NPL + 1);
    check_val("inside_starts", starts, 0);
    check_val("inside_v1", o_v1, va);
    check_val("inside_v2", o_v2, vb);
    check_val("inside_reject", o_rej, 1'b0);
    check_val("inside_idle", idle_after, 1'b1);

    // Both outside -x: reject at plane 1
    va = mk(20'h200, 20'h0, 20'h0, 20'h100);
    vb = mk(20'h300, 20'h0, 20'h0, 20'h100);
    run_seg(va, vb, '0, 1, 1'b0, 0);
    check_val("reject_lat", lat, 3);
    check_val("reject_flag", o_rej, 1'b1);
    check_val("reject_v1", o_v1, va);
    check_val("reject_v2", o_v2, vb);
    check_val("reject_starts", starts, 0);

    // Clip v2 on -x, 1-cycle unit, 5 cycles of back-pressure
    va = mk(20'h0, 20'h0, 20'h0, 20'h100);
    vb = mk(20'h200, 20'h0, 20'h0, 20'h100);
    vp = mk(20'h100, 20'h0, 20'h0, 20'h100);
    run_seg(va, vb, vp, 1, 1'b0, 5);
    check_val("clipx_starts", starts, 1);
    check_val("clipx_plane", plane_s, mk(20'hFFF00, 20'h0, 20'h0, 20'h100));
    check_val("clipx_isect_v1", iv1_s, va);
    check_val("clipx_isect_v2", iv2_s, vb);
    check_val("clipx_op_held", op_held, 1'b1);
    check_val("clipx_lat", lat, NPL + 3);
    check_val("clipx_v1", o_v1, va);
    check_val("clipx_v2", o_v2, vp);
    check_val("clipx_reject", o_rej, 1'b0);
    check_val("bp_stable", stable, 1'b1);
    check_val("bp_idle_after", idle_after, 1'b1);

    // Clip v1 on +y, 3-cycle unit
    va = mk(20'h0, 20'hFFE00, 20'h0, 20'h100);
    vb = mk(20'h0, 20'h0, 20'h0, 20'h100);
    vp = mk(20'h0, 20'hFFF00, 20'h0, 20'h100);
    run_seg(va, vb, vp, 3, 1'b0, 0);
    check_val("clipy_starts", starts, 1);
    check_val("clipy_plane", plane_s, mk(20'h0, 20'h100, 20'h0, 20'h100));
    check_val("clipy_op_held", op_held, 1'b1);
    check_val("clipy_lat", lat, NPL + 5);
    check_val("clipy_v1", o_v1, vp);
    check_val("clipy_v2", o_v2, vb);

    // Segment beyond -z: passes untouched without z planes, rejected at plane 5 with them
    va = mk(20'h0, 20'h0, 20'h200, 20'h100);
    vb = mk(20'h0, 20'h0, 20'h300, 20'h100);
    run_seg(va, vb, '0, 1, 1'b0, 0);
`ifdef CLIP_ZPLANES_EN
    check_val("zseg_lat", lat, 7);
    check_val("zseg_reject", o_rej, 1'b1);
`else
    check_val("zseg_lat", lat, 5);
    check_val("zseg_reject", o_rej, 1'b0);
`endif
    check_val("zseg_v1", o_v1, va);
    check_val("zseg_v2", o_v2, vb);

    // Reset while waiting on the intersection unit, then a late done
    va = mk(20'h0, 20'h0, 20'h0, 20'h100);
    vb = mk(20'h200, 20'h0, 20'h0, 20'h100);
    @(negedge clk_i);
    in_valid_i = 1'b1; in_v1_i = va; in_v2_i = vb;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    n = 0;
    while (!isect_start_o && n < 20) begin
      @(posedge clk_i); #1;
      n++;
    end
    check_val("rstw_start_seen", isect_start_o, 1'b1);
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    #1;
    check_val("rstw_in_ready", in_ready_o, 1'b1);
    check_val("rstw_out_valid", out_valid_o, 1'b0);
    check_val("rstw_isect_start", isect_start_o, 1'b0);
    check_val("rstw_reject", out_reject_o, 1'b0);
    check_val("rstw_out_v1", out_v1_o, '0);
    check_val("rstw_out_v2", out_v2_o, '0);
    check_val("rstw_isect_v2", isect_v2_o, '0);
    check_val("rstw_isect_plane", isect_plane_o, '0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    isect_done_i = 1'b1;
    isect_p_i    = mk(20'h100, 20'h0, 20'h0, 20'h100);
    @(posedge clk_i); #1;
    isect_done_i = 1'b0;
    isect_p_i    = '0;
    @(posedge clk_i); #1;
    check_val("late_in_ready", in_ready_o, 1'b1);
    check_val("late_out_valid", out_valid_o, 1'b0);
    check_val("late_out_v2", out_v2_o, '0);
    check_val("late_isect_start", isect_start_o, 1'b0);

    // Normal operation after recovery
    va = mk(20'h10, 20'h20, 20'h30, 20'h100);
    vb = mk(20'hFFFF0, 20'hFFFE0, 20'hFFFD0, 20'h100);
    run_seg(va, vb, '0, 1, 1'b0, 0);
    check_val("recov_lat", lat, NPL + 1);
    check_val("recov_v1", o_v1, va);
    check_val("recov_v2", o_v2, vb);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/clip_line_ctrl.md
CLIP_LINE_CTRL -- requirements
Module: clip_line_ctrl

Interface
REQ-001 Parameter WIDTH, default 20; the vertex/plane component width in signed 12.8 fixed point (1.0 = 0x00100).
REQ-002 clk_i  input  1  the single clock.
REQ-003 rst_ni  input  1  asynchronous active-low reset.
REQ-004 in_valid_i  input  1  input segment valid. in_ready_o  output  1  controller idle and able to accept.
REQ-005 in_v1_i, in_v2_i  input  4*WIDTH each  segment endpoints as {x,y,z,w}, vec4_t.
REQ-006 out_valid_o  output  1, out_ready_i  input  1  result handshake.
REQ-007 out_v1_o, out_v2_o  output  4*WIDTH each  clipped endpoints; out_reject_o  output  1  segment fully outside.
REQ-008 isect_start_o  output  1  one-cycle start pulse to the intersection unit.
REQ-009 isect_v1_o, isect_v2_o, isect_plane_o  output  4*WIDTH each  operands to the intersection unit; the plane is {a,b,c,d}.
REQ-010 isect_done_i  input  1; isect_p_i  input  4*WIDTH  intersection point, valid while isect_done_i=1.

Function
REQ-011 States SHALL be IDLE, TEST, ISSUE, WAIT, OUT.
REQ-012 in_ready_o SHALL be 1 only in IDLE. A handshake SHALL latch both vertices, clear the plane index to 0, and enter TEST.
REQ-013 Plane order 0..5 SHALL be: +x(1,0,0,1), -x(-1,0,0,1), +y(0,1,0,1), -y(0,-1,0,1), +z(0,0,1,1), -z(0,0,-1,1).
REQ-014 TEST SHALL take one cycle per plane and compute d1 = w1 +/- coord1 and d2 likewise. Both sums SHALL be WIDTH+1 bits signed, with no saturation. Inside means d >= 0.
REQ-015 In TEST, both inside SHALL advance to the next plane.
REQ-016 In TEST, both outside SHALL set reject and go to OUT.
REQ-017 In TEST, exactly one outside SHALL go to ISSUE.
REQ-018 In ISSUE, isect_start_o SHALL be 1 for exactly one cycle, with the current vertices and the plane coefficients driven. The controller SHALL then go to WAIT.
REQ-019 In WAIT, the controller SHALL hold the operands stable until isect_done_i=1.
REQ-020 On that cycle, isect_p_i SHALL replace the outside vertex: v1 if d1<0, else v2. The controller SHALL then advance the plane.
REQ-021 isect_done_i SHALL be ignored outside WAIT.
REQ-022 Advancing past the last enabled plane SHALL enter OUT.
REQ-023 In OUT, out_valid_o SHALL be 1 and out_v1_o, out_v2_o and out_reject_o SHALL be held stable until out_ready_i=1. The controller SHALL then return to IDLE.
REQ-024 The handshake cycle and the OUT exit SHALL NOT overlap; in_ready_o=0 in OUT.
REQ-025 Latency with no clipping and 6 planes: out_valid_o SHALL rise 7 cycles after the input handshake. Each clip SHALL add 1 + (WAIT cycles) cycles, which is 2 with a 1-cycle intersection unit.
REQ-026 A reject SHALL terminate the plane scan immediately; later planes SHALL NOT be tested.
REQ-027 out_v1_o and out_v2_o on reject SHALL be the latched vertices at the time of rejection.

Reset
REQ-028 While rst_ni=0, the state SHALL be IDLE.
REQ-029 While rst_ni=0, out_valid_o=0, isect_start_o=0, out_reject_o=0, and all vertex/plane outputs=0.
REQ-030 While rst_ni=0, in_ready_o=1.
REQ-031 Reset asserted mid-operation (any state, including WAIT) SHALL discard the segment. A late isect_done_i after release SHALL be ignored.

Configuration
REQ-032 Macro CLIP_ZPLANES_EN defined: all 6 planes SHALL be tested.
REQ-033 Macro CLIP_ZPLANES_EN undefined: only planes 0..3 SHALL be tested, and z SHALL pass through unclipped. No-clip latency SHALL then be 5 cycles.

Structure
REQ-034 Package clip_pkg SHALL hold the vec4_t typedef, the state enum, the plane count constant, and the 6-entry plane coefficient table.
REQ-035 One sub-module, clip_plane_dist, SHALL compute the combinational d1/d2 and the inside flags for a given plane index.

Verification
REQ-036 Fully inside: v1=(0,0,0,0x100), v2=(0x80,0,0,0x100) -> out_valid_o at cycle 7, vertices unchanged, out_reject_o=0, isect_start_o never 1.
REQ-037 Reject: v1=(0x200,0,0,0x100), v2=(0x300,0,0,0x100) -> the scan stops at plane 1; out_valid_o at cycle 3, out_reject_o=1.
REQ-038 Clip on -x: v1=(0,0,0,0x100), v2=(0x200,0,0,0x100); the bench model returns (0x100,0,0,0x100) one cycle after start.
  -> One isect_start_o pulse with isect_plane_o=(0xFFF00,0,0,0x100).
  -> out_v2_o=(0x100,0,0,0x100), out_v1_o unchanged, out_valid_o at cycle 9.
REQ-039 Back-pressure: out_ready_i=0 for 5 cycles in OUT -> outputs stable, in_ready_o=0; release -> IDLE next cycle.
REQ-040 Reset in WAIT: rst_ni=0 for 1 cycle -> all outputs 0, in_ready_o=1. A subsequent stray isect_done_i SHALL cause no state change.
REQ-041 Macro off: v1=(0,0,0x200,0x100), v2=(0,0,0x300,0x100) -> out_reject_o=0, vertices unchanged, out_valid_o at cycle 5.
